// File: rtl/bp_cce_uc_responder.sv
// Uncached-only directory responder for a two-port BedRock LCE interface.
// It serves one request at a time through a single 64-bit memory port.
package bp_cce_uc_pkg;
  localparam int paddr_width_p     = 40;
  localparam int cce_id_width_p    = 3;
  localparam int lce_id_width_p    = 3;
  localparam int cce_block_width_p = 512;

  typedef enum logic [3:0] {
    e_bedrock_req_rd_miss = 4'd0,
    e_bedrock_req_wr_miss = 4'd1,
    e_bedrock_req_uc_rd   = 4'd2,
    e_bedrock_req_uc_wr   = 4'd3,
    e_bedrock_req_uc_amo  = 4'd4
  } bp_bedrock_req_type_e;

  typedef enum logic [3:0] {
    e_bedrock_cmd_sync       = 4'd0,
    e_bedrock_cmd_set_clear  = 4'd1,
    e_bedrock_cmd_inv        = 4'd2,
    e_bedrock_cmd_st         = 4'd3,
    e_bedrock_cmd_data       = 4'd4,
    e_bedrock_cmd_st_wakeup  = 4'd5,
    e_bedrock_cmd_wb         = 4'd6,
    e_bedrock_cmd_st_wb      = 4'd7,
    e_bedrock_cmd_tr         = 4'd8,
    e_bedrock_cmd_st_tr      = 4'd9,
    e_bedrock_cmd_st_tr_wb   = 4'd10,
    e_bedrock_cmd_uc_data    = 4'd11,
    e_bedrock_cmd_uc_st_done = 4'd12
  } bp_bedrock_cmd_type_e;

  typedef enum logic [2:0] {
    e_COH_I = 3'b000,
    e_COH_S = 3'b001,
    e_COH_E = 3'b010,
    e_COH_F = 3'b011,
    e_COH_M = 3'b110,
    e_COH_O = 3'b111
  } bp_coh_states_e;

  typedef enum logic [1:0] {
    e_ready    = 2'd0,
    e_mem_cmd  = 2'd1,
    e_mem_resp = 2'd2,
    e_send_cmd = 2'd3
  } bp_cce_uc_state_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0] src_id;
    logic [2:0]                size;
    logic [paddr_width_p-1:0]  addr;
    bp_bedrock_req_type_e      msg_type;
  } bp_bedrock_lce_req_header_s;

  typedef struct packed {
    bp_coh_states_e            state;
    logic [2:0]                way_id;
    logic [cce_id_width_p-1:0] src_id;
    logic [lce_id_width_p-1:0] dst_id;
    logic [2:0]                size;
    logic [paddr_width_p-1:0]  addr;
    bp_bedrock_cmd_type_e      msg_type;
  } bp_bedrock_lce_cmd_header_s;

  localparam int lce_req_header_width_lp = $bits(bp_bedrock_lce_req_header_s);
  localparam int lce_cmd_header_width_lp = $bits(bp_bedrock_lce_cmd_header_s);
endpackage

module bp_cce_uc_responder
  import bp_cce_uc_pkg::*;
(
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [cce_id_width_p-1:0]              cce_id_i,
  input  bp_bedrock_lce_req_header_s [1:0]       lce_req_header_i,
  input  logic [1:0][cce_block_width_p-1:0]      lce_req_data_i,
  input  logic [1:0]                             lce_req_v_i,
  output logic [1:0]                             lce_req_ready_and_o,
  output bp_bedrock_lce_cmd_header_s [1:0]       lce_cmd_header_o,
  output logic [1:0][cce_block_width_p-1:0]      lce_cmd_data_o,
  output logic [1:0]                             lce_cmd_v_o,
  input  logic [1:0]                             lce_cmd_yumi_i,
  output logic                                   mem_cmd_v_o,
  output logic                                   mem_cmd_w_o,
  output logic [paddr_width_p-1:0]               mem_cmd_addr_o,
  output logic [1:0]                             mem_cmd_size_o,
  output logic [63:0]                            mem_cmd_data_o,
  input  logic                                   mem_cmd_ready_and_i,
  input  logic                                   mem_resp_v_i,
  input  logic [63:0]                            mem_resp_data_i,
  output logic                                   error_o,
  output bp_cce_uc_state_e                       debug_state_o
);

  localparam int block_lanes_lp = cce_block_width_p / 64;

  // Handshakes: a transfer happens on a posedge where valid and ready_and (or
  // yumi) are both high; valid/data are held stable until that edge.
  bp_cce_uc_state_e           state_q, state_n;
  logic                       rr_q;
  logic                       error_q;
  logic                       port_q;
  bp_bedrock_lce_req_header_s hdr_q;
  logic [63:0]                data_q;
  logic [63:0]                resp_q;

  logic                       grant_port;
  logic                       req_hs;
  logic                       req_supported;
  bp_bedrock_lce_req_header_s sel_hdr;
  bp_bedrock_lce_cmd_header_s cmd_hdr;
  logic [cce_block_width_p-1:0] cmd_data;
  logic                       hdr_is_rd;

  // Upper payload bits are carried by the interface but never used here.
  logic unused_req_data;
  assign unused_req_data = ^{lce_req_data_i[0][cce_block_width_p-1:64],
                             lce_req_data_i[1][cce_block_width_p-1:64]};

  always_comb begin
    grant_port    = (&lce_req_v_i) ? rr_q : lce_req_v_i[1];
    req_hs        = (state_q == e_ready) && (|lce_req_v_i);
    sel_hdr       = lce_req_header_i[grant_port];
    req_supported = (sel_hdr.msg_type == e_bedrock_req_uc_rd)
                 || (sel_hdr.msg_type == e_bedrock_req_uc_wr);
    lce_req_ready_and_o = req_hs ? {grant_port, ~grant_port} : 2'b00;

    state_n = state_q;
    case (state_q)
      e_ready:    if (req_hs && req_supported) state_n = e_mem_cmd;
      e_mem_cmd:  if (mem_cmd_ready_and_i)     state_n = e_mem_resp;
      e_mem_resp: if (mem_resp_v_i)            state_n = e_send_cmd;
      e_send_cmd: if (lce_cmd_yumi_i[port_q])  state_n = e_ready;
      default:                                 state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_ready;
      rr_q    <= 1'b0;
      error_q <= 1'b0;
      port_q  <= 1'b0;
      hdr_q   <= '0;
      data_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_n;
      if (req_hs) begin
        rr_q   <= ~grant_port;
        port_q <= grant_port;
        hdr_q  <= sel_hdr;
        data_q <= lce_req_data_i[grant_port][63:0];
        if (!req_supported) error_q <= 1'b1;
      end
      if ((state_q == e_mem_resp) && mem_resp_v_i) resp_q <= mem_resp_data_i;
    end
  end

  always_comb begin
    hdr_is_rd      = (hdr_q.msg_type == e_bedrock_req_uc_rd);
    mem_cmd_v_o    = (state_q == e_mem_cmd);
    mem_cmd_w_o    = mem_cmd_v_o && (hdr_q.msg_type == e_bedrock_req_uc_wr);
    mem_cmd_addr_o = mem_cmd_v_o ? hdr_q.addr : '0;
    mem_cmd_size_o = mem_cmd_v_o ? hdr_q.size[1:0] : 2'b00;
    mem_cmd_data_o = mem_cmd_v_o ? data_q : 64'd0;

    cmd_hdr          = '0;
    cmd_hdr.msg_type = hdr_is_rd ? e_bedrock_cmd_uc_data : e_bedrock_cmd_uc_st_done;
    cmd_hdr.addr     = hdr_q.addr;
    cmd_hdr.size     = hdr_q.size;
    cmd_hdr.dst_id   = hdr_q.src_id;
    cmd_hdr.src_id   = cce_id_i;
    cmd_hdr.way_id   = 3'd0;
    cmd_hdr.state    = e_COH_I;
    cmd_data         = hdr_is_rd ? {block_lanes_lp{resp_q}} : '0;

    for (int p = 0; p < 2; p++) begin
      lce_cmd_v_o[p]      = (state_q == e_send_cmd) && (port_q == p[0]);
      lce_cmd_header_o[p] = lce_cmd_v_o[p] ? cmd_hdr : '0;
      lce_cmd_data_o[p]   = lce_cmd_v_o[p] ? cmd_data : '0;
    end

    error_o       = error_q;
    debug_state_o = state_q;
  end

  // A memory response is only legal while one is being awaited.
  assert property (@(posedge clk_i) disable iff (reset_i)
    mem_resp_v_i |-> (state_q == e_mem_resp));

endmodule
